wts_timer_array: RTL and testbench
==================================

Name: wts_timer_array

Overview:
Parametrised bank of NUM_TIMERS programmable down-counting timers for the WTS cartridge. It supersedes the fixed two-timer block. Each timer adds a 16-bit reload value, a prescaler, a one-shot/periodic mode and an interrupt-enable bit. The block sits behind the slot register decoder, counts on the sound engine's tick strobe, and drives the combined active-low interrupt that the top level turns into open-collector slot_nint.

Parameters:
NUM_TIMERS, 4, number of timers (1..16)
COUNT_W, 16, reload/counter width (8..16)
ADDR_W, 6, register address width; must be >= clog2(NUM_TIMERS)+2

Ports:
clk  in  1  system clock (21.47727 MHz)
nreset  in  1  synchronous active-low reset
tick_en  in  1  timebase strobe, one clk wide
bus_addr  in  ADDR_W  register address (timer t at t*4 .. t*4+3)
bus_wr  in  1  single-cycle write strobe
bus_rd  in  1  single-cycle read strobe
bus_wdata  in  8  write data
bus_rdata  out  8  read data, registered
nint  out  1  combined interrupt, active low, level
timer_fire  out  NUM_TIMERS  one-clk pulse per timer expiry

Behaviour:
- Clock is clk. Reset is nreset, synchronous and active-low. All state is cleared on the clk edge that samples nreset=0.
- Reset values: every ctrl=0, reload=0, counter=0, prescaler=0, pending=0; bus_rdata=8'h00, nint=1, timer_fire=0.
- Register map, offset within each timer:
  - +0 CTRL (R/W): bit7 EN, bit6 ONESHOT, bit5 IE, bits3:0 PSEL. Bit4 reads 0.
  - +1 STATUS (R): bit7 = ~pending; bits6:0 read 0. Reads 8'h80 when idle and 8'h00 when expired.
  - +2 RELOAD_L (R/W).
  - +3 RELOAD_H (R/W); bits above COUNT_W are ignored and read 0.
- Addresses at or above NUM_TIMERS*4 read 8'h00 and ignore writes.
- Read path: bus_rdata updates on the clk edge after the bus_rd cycle and holds until the next read.
- STATUS read side effect: reading STATUS clears that timer's pending bit on the same edge. The returned value is the pre-clear value.
- Writing CTRL with EN=1, whether enabling or already running:
  - counter <= reload, prescaler <= 0 (restart).
  - Pending is not changed.
- Writing CTRL with EN=0 freezes the counter and prescaler. Pending is retained.
- RELOAD writes do not disturb a running counter. The new value applies at the next load.
- Count event: EN=1, tick_en=1 and prescaler == 2^PSEL-1. The prescaler is COUNT_W-independent, 15 bits wide, increments on each tick_en while EN=1, and clears on a count event. PSEL=0 gives a count event on every tick.
- On a count event:
  - If counter != 0: counter <= counter-1.
  - If counter == 0 (expiry): pending <= 1, timer_fire[t] pulses for 1 clk, and counter <= reload.
  - After expiry, ONESHOT=1 clears EN on the same edge; ONESHOT=0 keeps running.
- Period is (reload+1) count events. reload=0 expires on the first count event after enable.
- Simultaneous expiry and STATUS read of the same timer: expiry wins and pending stays 1. The read returns the old value.
- Simultaneous CTRL write and count event: the write wins (restart). No expiry occurs in that cycle.
- nint = ~|(pending[t] & IE[t]), registered, so it follows pending by 1 clk. Clearing IE releases nint but does not clear pending.
- Reset asserted mid-count aborts immediately: no fire pulse, all registers return to reset values.
- Timers are fully independent. Several may expire in the same cycle.

Test Plan:
- Reset: all STATUS read 8'h80, CTRL read 8'h00, nint=1, bus_rdata=8'h00.
- One-shot basic (tick_en=1): timers 0 and 1 get CTRL=8'hE0, reload 0 -> pending set, nint=0 within 3 clk. Reads of STATUS 0 and 1 return 8'h00, then 8'h80 on re-read. nint returns to 1. CTRL bit7 reads 0.
- Periodic with prescaler: timer 2 gets reload=3, CTRL=8'hA2 (PSEL=2), tick_en=1 -> timer_fire[2] pulses every 16 clk, at least 4 times. EN stays 1.
- Interrupt mask: timer 3 gets CTRL=8'h80 (IE=0), reload 0 -> STATUS reads 8'h00 but nint stays 1. Then write CTRL=8'hA0 -> nint goes 0 once the new expiry sets pending.
- Collision: arrange a STATUS read in the expiry cycle -> read returns 8'h80 and the following read returns 8'h00. A CTRL write in a count-event cycle -> no timer_fire pulse that cycle.
- Mid-operation reset: assert nreset for 1 clk while timer 0 is running periodic -> no timer_fire afterwards, all registers at reset values, nint=1.

Source files
------------

// File: rtl/wts_timer_array_if.sv
// Register bus between the slot decoder and the timer bank.
// The decoder drives address, strobes and write data; the timer bank
// returns registered read data.
interface wts_timer_array_if #(
  parameter int ADDR_W = 6
) ();
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              rd;
  logic [7:0]        wdata;
  logic [7:0]        rdata;

  modport master (output addr, output wr, output rd, output wdata, input rdata);
  modport slave  (input addr, input wr, input rd, input wdata, output rdata);
endinterface

// File: rtl/wts_timer_array.sv
// Bank of NUM_TIMERS programmable down-counting timers.
// Each timer owns four byte registers (CTRL, STATUS, RELOAD_L, RELOAD_H).
// It counts on tick_en through a 2^PSEL prescaler and raises a pending
// flag plus a one-clock fire pulse on expiry. Pending flags gated by IE
// combine into the active-low level interrupt nint.
module wts_timer_array #(
  parameter int NUM_TIMERS = 4,
  parameter int COUNT_W    = 16,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  tick_en,
  wts_timer_array_if.slave      bus,
  output logic                  nint,
  output logic [NUM_TIMERS-1:0] timer_fire
);

  localparam int IDX_W = ADDR_W - 2;

  // Terminal prescaler value for a given PSEL: 2^PSEL - 1.
  function automatic logic [14:0] psel_mask(input logic [3:0] psel);
    logic [15:0] m;
    m = (16'd1 << psel) - 16'd1;
    return m[14:0];
  endfunction

  // Zero-extend a reload value to the 16-bit register-map view.
  function automatic logic [15:0] ext16(input logic [COUNT_W-1:0] v);
    return 16'(v);
  endfunction

  logic [7:0]         ctrl_r    [NUM_TIMERS];
  logic [COUNT_W-1:0] reload_r  [NUM_TIMERS];
  logic [COUNT_W-1:0] counter_r [NUM_TIMERS];
  logic [14:0]        presc_r   [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] pending_r;
  logic [NUM_TIMERS-1:0] fire_r;
  logic [7:0]            rdata_r;
  logic                  nint_r;

  logic                  hit_s;
  logic [IDX_W-1:0]      idx_s;
  logic [1:0]            off_s;
  logic [NUM_TIMERS-1:0] sel_s;
  logic [NUM_TIMERS-1:0] ie_s;
  logic [NUM_TIMERS-1:0] wr_ctrl_s;
  logic [NUM_TIMERS-1:0] wr_rl_s;
  logic [NUM_TIMERS-1:0] wr_rh_s;
  logic [NUM_TIMERS-1:0] rd_stat_s;
  logic [NUM_TIMERS-1:0] count_ev_s;
  logic [NUM_TIMERS-1:0] expire_s;
  logic [15:0]           rl16_s    [NUM_TIMERS];
  logic [COUNT_W-1:0]    rl_lo_new_s [NUM_TIMERS];
  logic [COUNT_W-1:0]    rl_hi_new_s [NUM_TIMERS];
  logic [7:0]            rd_tim_s  [NUM_TIMERS];
  logic [7:0]            rd_val_s;

  // Address decode, per-timer strobes, count/expiry detection and read mux.
  always_comb begin
    idx_s    = bus.addr[ADDR_W-1:2];
    off_s    = bus.addr[1:0];
    hit_s    = (32'(bus.addr) < 32'(NUM_TIMERS * 4));
    rd_val_s = 8'h00;
    for (int t = 0; t < NUM_TIMERS; t++) begin
      sel_s[t]     = hit_s && (idx_s == IDX_W'(t));
      ie_s[t]      = ctrl_r[t][5];
      wr_ctrl_s[t] = bus.wr && sel_s[t] && (off_s == 2'd0);
      rd_stat_s[t] = bus.rd && sel_s[t] && (off_s == 2'd1);
      wr_rl_s[t]   = bus.wr && sel_s[t] && (off_s == 2'd2);
      wr_rh_s[t]   = bus.wr && sel_s[t] && (off_s == 2'd3);
      // A CTRL write in the same cycle restarts the timer instead of counting.
      count_ev_s[t] = ctrl_r[t][7] && tick_en && !wr_ctrl_s[t] &&
                      (presc_r[t] == psel_mask(ctrl_r[t][3:0]));
      expire_s[t]   = count_ev_s[t] && (counter_r[t] == {COUNT_W{1'b0}});
      rl16_s[t]      = ext16(reload_r[t]);
      rl_lo_new_s[t] = COUNT_W'({rl16_s[t][15:8], bus.wdata});
      rl_hi_new_s[t] = COUNT_W'({bus.wdata, rl16_s[t][7:0]});
      case (off_s)
        2'd0:    rd_tim_s[t] = ctrl_r[t];
        2'd1:    rd_tim_s[t] = {~pending_r[t], 7'b000_0000};
        2'd2:    rd_tim_s[t] = rl16_s[t][7:0];
        2'd3:    rd_tim_s[t] = rl16_s[t][15:8];
        default: rd_tim_s[t] = 8'h00;
      endcase
      rd_val_s = rd_val_s | (sel_s[t] ? rd_tim_s[t] : 8'h00);
    end
  end

  // Timer state, pending flags, fire pulses, read data and interrupt register.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      for (int t = 0; t < NUM_TIMERS; t++) begin
        ctrl_r[t]    <= 8'h00;
        reload_r[t]  <= {COUNT_W{1'b0}};
        counter_r[t] <= {COUNT_W{1'b0}};
        presc_r[t]   <= 15'd0;
      end
      pending_r <= {NUM_TIMERS{1'b0}};
      fire_r    <= {NUM_TIMERS{1'b0}};
      rdata_r   <= 8'h00;
      nint_r    <= 1'b1;
    end else begin
      if (bus.rd) begin
        rdata_r <= rd_val_s;
      end
      nint_r <= ~|(pending_r & ie_s);
      fire_r <= expire_s;
      for (int t = 0; t < NUM_TIMERS; t++) begin
        if (wr_rl_s[t]) begin
          reload_r[t] <= rl_lo_new_s[t];
        end else if (wr_rh_s[t]) begin
          reload_r[t] <= rl_hi_new_s[t];
        end
        if (wr_ctrl_s[t]) begin
          ctrl_r[t] <= {bus.wdata[7:5], 1'b0, bus.wdata[3:0]};
          if (bus.wdata[7]) begin
            counter_r[t] <= reload_r[t];
            presc_r[t]   <= 15'd0;
          end
        end else if (ctrl_r[t][7] && tick_en) begin
          if (count_ev_s[t]) begin
            presc_r[t] <= 15'd0;
            if (expire_s[t]) begin
              counter_r[t] <= reload_r[t];
              if (ctrl_r[t][6]) begin
                ctrl_r[t][7] <= 1'b0;
              end
            end else begin
              counter_r[t] <= counter_r[t] - {{(COUNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            presc_r[t] <= presc_r[t] + 15'd1;
          end
        end
        // Expiry beats a simultaneous STATUS read clear.
        if (expire_s[t]) begin
          pending_r[t] <= 1'b1;
        end else if (rd_stat_s[t]) begin
          pending_r[t] <= 1'b0;
        end
      end
    end
  end

  assign bus.rdata  = rdata_r;
  assign nint       = nint_r;
  assign timer_fire = fire_r;

endmodule

// File: tb/tb_wts_timer_array.sv
// Scoreboard bench for wts_timer_array: reads push expected data into a
// queue, a monitor pops and compares one clock after each read strobe and
// tallies fire pulses per timer.
module tb_wts_timer_array;

  logic       clk;
  logic       nreset;
  logic       tick_en;
  logic       nint;
  logic [3:0] timer_fire;

  wts_timer_array_if #(.ADDR_W(6)) bus_if ();

  wts_timer_array #(.NUM_TIMERS(4), .COUNT_W(16), .ADDR_W(6)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .tick_en    (tick_en),
    .bus        (bus_if),
    .nint       (nint),
    .timer_fire (timer_fire)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int fire_cnt [4];
  int fire_t2 [$];
  logic [13:0] exp_q [$];
  logic rd_seen = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.wr    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.wr = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e);
    bus_if.addr = a;
    bus_if.rd   = 1'b1;
    exp_q.push_back({a, e});
    @(posedge clk);
    #1;
    bus_if.rd = 1'b0;
  endtask

  // Cycle counter and read-strobe delay for the monitor.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_seen <= bus_if.rd;
  end

  // Monitor: count fire pulses and check read data against the scoreboard.
  always @(negedge clk) begin
    logic [13:0] e;
    for (int t = 0; t < 4; t++) begin
      if (timer_fire[t]) begin
        fire_cnt[t]++;
        if (t == 2) fire_t2.push_back(cyc);
      end
    end
    if (rd_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h expected no read", bus_if.rdata);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.rdata !== e[7:0]) begin
          errors++;
          $display("FAIL rd@%0h: got %0h expected %0h", e[13:8], bus_if.rdata, e[7:0]);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    for (int t = 0; t < 4; t++) fire_cnt[t] = 0;
    nreset       = 1'b0;
    tick_en      = 1'b0;
    bus_if.addr  = 6'd0;
    bus_if.wr    = 1'b0;
    bus_if.rd    = 1'b0;
    bus_if.wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_nint", 32'(nint), 32'd1);
    chk("rst_rdata", 32'(bus_if.rdata), 32'h00);
    chk("rst_fire", 32'(timer_fire), 32'h0);
    for (int t = 0; t < 4; t++) begin
      rd(6'(t * 4 + 1), 8'h80);
      rd(6'(t * 4), 8'h00);
    end

    // Register readback, out-of-range, CTRL bit4
    wr(6'd10, 8'h55);
    wr(6'd11, 8'hAB);
    rd(6'd10, 8'h55);
    rd(6'd11, 8'hAB);
    wr(6'd16, 8'hFF);
    rd(6'd16, 8'h00);
    rd(6'd0, 8'h00);
    wr(6'd12, 8'h1F);
    rd(6'd12, 8'h0F);
    wr(6'd12, 8'h00);

    tick_en = 1'b1;

    // One-shot on timers 0 and 1, reload 0
    fire_cnt[0] = 0;
    fire_cnt[1] = 0;
    wr(6'd0, 8'hE0);
    wr(6'd4, 8'hE0);
    repeat (3) @(posedge clk);
    #1;
    chk("os_nint_low", 32'(nint), 32'd0);
    chk("os_fire0", 32'(fire_cnt[0]), 32'd1);
    chk("os_fire1", 32'(fire_cnt[1]), 32'd1);
    rd(6'd1, 8'h00);
    rd(6'd1, 8'h80);
    rd(6'd5, 8'h00);
    rd(6'd5, 8'h80);
    rd(6'd0, 8'h60);
    rd(6'd4, 8'h60);
    repeat (2) @(posedge clk);
    #1;
    chk("os_nint_high", 32'(nint), 32'd1);

    // Periodic timer 2: reload 3, PSEL 2 -> 16 clk period
    wr(6'd10, 8'h03);
    wr(6'd11, 8'h00);
    fire_cnt[2] = 0;
    fire_t2.delete();
    wr(6'd8, 8'hA2);
    repeat (66) @(posedge clk);
    #1;
    chk("per_cnt", 32'(fire_cnt[2]), 32'd4);
    d = (fire_t2.size() >= 2) ? fire_t2[1] - fire_t2[0] : -1;
    chk("per_gap01", 32'(d), 32'd16);
    d = (fire_t2.size() >= 4) ? fire_t2[3] - fire_t2[2] : -1;
    chk("per_gap23", 32'(d), 32'd16);
    rd(6'd8, 8'hA2);
    wr(6'd8, 8'h00);
    rd(6'd9, 8'h00);
    rd(6'd9, 8'h80);

    // Interrupt mask on timer 3
    wr(6'd12, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    chk("mask_nint_high", 32'(nint), 32'd1);
    rd(6'd13, 8'h00);
    wr(6'd12, 8'hA0);
    repeat (3) @(posedge clk);
    #1;
    chk("mask_nint_low", 32'(nint), 32'd0);
    wr(6'd12, 8'h00);
    rd(6'd13, 8'h00);
    rd(6'd13, 8'h80);
    repeat (2) @(posedge clk);
    #1;
    chk("mask_nint_rel", 32'(nint), 32'd1);

    // Collision: STATUS read in the expiry cycle (timer 0, one-shot, IE=0)
    fire_cnt[0] = 0;
    wr(6'd0, 8'hC0);
    rd(6'd1, 8'h80);
    rd(6'd1, 8'h00);
    rd(6'd1, 8'h80);
    chk("col_fire0", 32'(fire_cnt[0]), 32'd1);

    // Collision: CTRL write in a count-event cycle (timer 1, periodic, reload 0)
    wr(6'd4, 8'h80);
    repeat (2) @(negedge clk);
    chk("col_fire_before", 32'(timer_fire[1]), 32'd1);
    wr(6'd4, 8'h80);
    @(negedge clk);
    chk("col_fire_blocked", 32'(timer_fire[1]), 32'd0);
    @(negedge clk);
    chk("col_fire_after", 32'(timer_fire[1]), 32'd1);
    wr(6'd4, 8'h00);
    rd(6'd5, 8'h00);
    rd(6'd5, 8'h80);

    // Mid-operation reset with timer 0 periodic, reload 2, IE=1
    wr(6'd2, 8'h02);
    wr(6'd3, 8'h00);
    wr(6'd0, 8'hA0);
    repeat (5) @(posedge clk);
    #1;
    chk("mr_nint_low", 32'(nint), 32'd0);
    rd(6'd2, 8'h02);
    @(negedge clk);
    nreset = 1'b0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    fire_cnt[0] = 0;
    @(negedge clk);
    chk("mr_fire", 32'(timer_fire), 32'h0);
    chk("mr_nint", 32'(nint), 32'd1);
    chk("mr_rdata", 32'(bus_if.rdata), 32'h00);
    repeat (20) @(posedge clk);
    #1;
    chk("mr_no_fire", 32'(fire_cnt[0]), 32'd0);
    rd(6'd0, 8'h00);
    rd(6'd1, 8'h80);
    rd(6'd2, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
